// File: rtl/boreal_spi_pkg.sv
// Shared types and constants for the ADS1299-style SPI frame ingest block.
package boreal_spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    CS_HOLD,
    DONE
  } state_e;

  localparam logic [3:0]  STATUS_SYNC = 4'hC;
  localparam int unsigned WORD_BITS   = 24;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/boreal_sync2.sv
// Two-flop synchronizer with a parameterised asynchronous reset value.
module boreal_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/boreal_spi_ingest.sv
// SPI master draining one status+channel frame per data-ready and forwarding
// the selected channel to the apex core with integrity and overrun reporting.
module boreal_spi_ingest
  import boreal_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned N_CH    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [2:0]  ch_sel,
  input  logic        drdy_n,
  input  logic        spi_miso,
  output logic        spi_sclk,
  output logic        spi_cs_n,
  output logic        data_valid,
  output logic [23:0] eeg_sample,
  output logic [23:0] status_word,
  output logic        frame_err,
  output logic [7:0]  overrun_cnt,
  output logic        busy
);

  localparam int unsigned DIV_W    = $clog2(2 * CLK_DIV);
  localparam logic [3:0]  WORD_END = 4'(N_CH + 1);
  localparam logic [2:0]  MAX_SEL  = 3'(N_CH - 1);

  logic drdy_s;
  logic miso_s;

  boreal_sync2 #(.RST_VAL(1'b1)) u_sync_drdy (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (drdy_n),
    .q_o   (drdy_s)
  );

  boreal_sync2 #(.RST_VAL(1'b0)) u_sync_miso (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (spi_miso),
    .q_o   (miso_s)
  );

  state_e                 state_q, state_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic [7:0]             bit_q, bit_d;
  logic [3:0]             word_q, word_d;
  logic [WORD_BITS-2:0]   shreg_q, shreg_d;
  logic [WORD_BITS-1:0]   hdr_q, hdr_d;
  logic [WORD_BITS-1:0]   smp_q, smp_d;
  logic [2:0]             sel_q, sel_d;
  logic                   ovr_flag_q, ovr_flag_d;
  logic                   drdy_prev_q;
  logic                   cs_n_q, cs_n_d;
  logic                   sclk_q, sclk_d;
  logic                   dv_q, dv_d;
  logic                   fe_q, fe_d;
  logic [23:0]            eeg_q, eeg_d;
  logic [23:0]            status_q, status_d;
  logic [7:0]             ovr_cnt_q, ovr_cnt_d;
  logic                   busy_q, busy_d;

  logic                   fall_c;
  logic [WORD_BITS-1:0]   word_c;

  assign fall_c = drdy_prev_q & ~drdy_s;
  assign word_c = {shreg_q, miso_s};

  // Pins follow state one cycle late so every output comes straight from a flop.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_d      = bit_q;
    word_d     = word_q;
    shreg_d    = shreg_q;
    hdr_d      = hdr_q;
    smp_d      = smp_q;
    sel_d      = sel_q;
    ovr_flag_d = ovr_flag_q;
    eeg_d      = eeg_q;
    status_d   = status_q;
    ovr_cnt_d  = ovr_cnt_q;
    dv_d       = 1'b0;
    fe_d       = 1'b0;
    cs_n_d     = !(state_q inside {CS_SETUP, SHIFT, CS_HOLD});
    sclk_d     = (state_q == SHIFT) && (div_q < DIV_W'(CLK_DIV));
    busy_d     = (state_q != IDLE);

    if (fall_c && (state_q != IDLE)) begin
      ovr_cnt_d  = sat_inc8(ovr_cnt_q);
      ovr_flag_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (fall_c && enable) begin
          state_d    = CS_SETUP;
          div_d      = '0;
          bit_d      = '0;
          word_d     = '0;
          ovr_flag_d = 1'b0;
          sel_d      = ({1'b0, ch_sel} > 4'(N_CH - 1)) ? MAX_SEL : ch_sel;
        end
      end
      CS_SETUP: begin
        if (div_q == DIV_W'(CLK_DIV - 1)) begin
          state_d = SHIFT;
          div_d   = '0;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      SHIFT: begin
        // Sample on the cycle SCLK is driven low (mode 1 falling edge).
        if (div_q == DIV_W'(CLK_DIV)) begin
          shreg_d = word_c[WORD_BITS-2:0];
          if (bit_q == 8'(WORD_BITS - 1)) begin
            bit_d  = '0;
            word_d = word_q + 4'd1;
            if (word_q == 4'd0) hdr_d = word_c;
            if (word_q == ({1'b0, sel_q} + 4'd1)) smp_d = word_c;
          end else begin
            bit_d = bit_q + 8'd1;
          end
        end
        if (div_q == DIV_W'(2 * CLK_DIV - 1)) begin
          div_d = '0;
          if (word_q == WORD_END) state_d = CS_HOLD;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      CS_HOLD: begin
        if (div_q == DIV_W'(CLK_DIV - 1)) begin
          state_d = DONE;
          div_d   = '0;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        if ((hdr_q[23:20] == STATUS_SYNC) && !ovr_flag_q && !fall_c) begin
          dv_d     = 1'b1;
          eeg_d    = smp_q;
          status_d = hdr_q;
        end else begin
          fe_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      div_q       <= '0;
      bit_q       <= '0;
      word_q      <= '0;
      shreg_q     <= '0;
      hdr_q       <= '0;
      smp_q       <= '0;
      sel_q       <= '0;
      ovr_flag_q  <= 1'b0;
      drdy_prev_q <= 1'b1;
      cs_n_q      <= 1'b1;
      sclk_q      <= 1'b0;
      dv_q        <= 1'b0;
      fe_q        <= 1'b0;
      eeg_q       <= '0;
      status_q    <= '0;
      ovr_cnt_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      word_q      <= word_d;
      shreg_q     <= shreg_d;
      hdr_q       <= hdr_d;
      smp_q       <= smp_d;
      sel_q       <= sel_d;
      ovr_flag_q  <= ovr_flag_d;
      drdy_prev_q <= drdy_s;
      cs_n_q      <= cs_n_d;
      sclk_q      <= sclk_d;
      dv_q        <= dv_d;
      fe_q        <= fe_d;
      eeg_q       <= eeg_d;
      status_q    <= status_d;
      ovr_cnt_q   <= ovr_cnt_d;
      busy_q      <= busy_d;
    end
  end

  assign spi_cs_n    = cs_n_q;
  assign spi_sclk    = sclk_q;
  assign data_valid  = dv_q;
  assign frame_err   = fe_q;
  assign eeg_sample  = eeg_q;
  assign status_word = status_q;
  assign overrun_cnt = ovr_cnt_q;
  assign busy        = busy_q;

endmodule

// File: doc/boreal_spi_ingest.md
# boreal_spi_ingest

SPI master that drains one ADS1299-format frame (24-bit status word followed by N_CH 24-bit channel words) each time the ADC signals data-ready. It selects one target channel and presents it to `boreal_apex_core` as a single-cycle `data_valid` strobe with a signed 24-bit sample. It sits directly upstream of the apex core, between the analog front-end pins and the core's `raw_eeg_in`/`data_valid` inputs. It also checks frame integrity and reports frames lost to data-ready overrun.

## Interface

Parameters:
- `CLK_DIV`, default 4. SCLK half-period in `clk` cycles. Legal range is 3 or more.
- `N_CH`, default 8. Channel words per frame. Legal range is 1 to 8.

Ports:
- `clk`  input  1  100 MHz system clock.
- `rst_n`  input  1  Reset. Asynchronous, active-low.
- `enable`  input  1  When low, new frames are not started. A frame already in progress completes normally.
- `ch_sel`  input  3  Target channel index. Latched at frame start. Values of `N_CH` or above are treated as `N_CH-1`.
- `drdy_n`  input  1  ADC data-ready, active-low. Asynchronous to `clk`.
- `spi_miso`  input  1  ADC serial data out. Asynchronous to `clk`.
- `spi_sclk`  output  1  SPI clock, CPOL=0.
- `spi_cs_n`  output  1  Chip select, active-low.
- `data_valid`  output  1  One-cycle strobe: a new valid sample is available.
- `eeg_sample`  output  24  Signed selected-channel word. Held between strobes. Connects to `raw_eeg_in`.
- `status_word`  output  24  Header of the last accepted frame.
- `frame_err`  output  1  One-cycle strobe: frame discarded.
- `overrun_cnt`  output  8  Overrun count. Saturating.
- `busy`  output  1  High from `spi_cs_n` fall to frame end.

## Operation

- `drdy_n` and `spi_miso` each pass through a 2-FF synchronizer.
- A falling edge on synchronized `drdy_n` while in IDLE with `enable=1` starts a frame.
- States and transitions:
  - IDLE → CS_SETUP on `drdy_n` fall. `spi_cs_n` goes low and `ch_sel` is latched.
  - CS_SETUP holds for `CLK_DIV` cycles, then → SHIFT.
  - SHIFT clocks `BITS = 24*(N_CH+1)` bits. Each bit is `CLK_DIV` cycles with SCLK high, then `CLK_DIV` cycles with SCLK low. The synchronized `spi_miso` is sampled, MSB-first, on the cycle SCLK is driven low (falling edge, SPI mode 1). After the last bit → CS_HOLD.
  - CS_HOLD holds for `CLK_DIV` cycles with SCLK low, then raises `spi_cs_n` → DONE.
  - DONE lasts 1 cycle and evaluates the frame, then → IDLE.
- Datapath: a 24-bit shift register plus a bit counter (8 bits) and a word counter (4 bits).
  - Word 0 is captured as the header.
  - Word `ch_sel_latched+1` is captured as the sample.
  - Other words are shifted and discarded.
- Frame evaluation in DONE:
  - The frame is good if header[23:20] equals `STATUS_SYNC` (4'hC) and no overrun occurred during the frame.
  - Good frame: update `eeg_sample` and `status_word`, pulse `data_valid`.
  - Bad frame: pulse `frame_err`. `eeg_sample` and `status_word` keep their previous values.
- Overrun: a `drdy_n` falling edge while `busy` (any state other than IDLE) increments `overrun_cnt`, saturating at 255. It marks the current frame bad and does not start a new frame. The next frame starts only on a subsequent `drdy_n` fall seen in IDLE.
- `enable` low in IDLE: `drdy_n` edges are ignored and do not count as overruns.

## Timing

- Reset values: `spi_cs_n=1`, `spi_sclk=0`, `data_valid=0`, `frame_err=0`, `eeg_sample=0`, `status_word=0`, `overrun_cnt=0`, `busy=0`, state IDLE.
- T0 is the `clk` edge at which the first sync FF captures `drdy_n=0`.
  - `spi_cs_n` falls at T0+3.
  - `data_valid`/`frame_err` asserts at T0+3+2·CLK_DIV·(BITS+1). With defaults this is T0+1739.
- Every output is registered. There are no combinational input-to-output paths.
- Reset asserted mid-frame: `spi_cs_n` goes high and `spi_sclk` goes low immediately (asynchronously). No strobe is issued. `overrun_cnt` clears.
- A `drdy_n` fall on the same cycle as DONE counts as an overrun against the current frame. That frame is reported as `frame_err`.
- Minimum frame spacing is T0-to-T0 ≥ 2·CLK_DIV·(BITS+1)+6 cycles.

## Structure

- Package `boreal_spi_pkg` holds:
  - the state enum (IDLE, CS_SETUP, SHIFT, CS_HOLD, DONE);
  - `STATUS_SYNC=4'hC`;
  - `WORD_BITS=24`.
- Sub-module `boreal_sync2`: a 2-FF synchronizer with an async active-low reset value parameter. It is instantiated for `drdy_n` (reset value 1) and `spi_miso` (reset value 0).

## Test plan

- Basic frame: ADC model with header 0xC00000, channels ch k = 0x010000·k+0x123, `ch_sel=3`. Required: `eeg_sample=0x030123`, `status_word=0xC00000`, one `data_valid` at T0+1739, exactly 216 SCLK rising edges.
- Sign: ch0 = 0x800001, `ch_sel=0`. Required: `eeg_sample=0x800001`, so the core sees -8388607.
- Bad header 0x400000. Required: `frame_err` pulse, no `data_valid`, previous `eeg_sample` retained.
- Overrun: second `drdy_n` fall at T0+800. Required: `overrun_cnt=1`, `frame_err` at T0+1739, no new frame until the next `drdy_n` fall in IDLE. Repeat 300 overruns; required: `overrun_cnt` saturates at 255.
- Reset asserted at T0+500. Required: `spi_cs_n=1` and `spi_sclk=0` within the same cycle, no strobe, a clean frame on the next `drdy_n` after release.
- `enable=0` with `drdy_n` toggling: no SCLK activity, `overrun_cnt` unchanged. `ch_sel=7` with `N_CH=4`: channel 3 is selected.
